// File: rtl/johnson_code_checker.sv
// Johnson code checker: decodes and validates an N-bit Johnson code stream, tracks successor lock and errors.
// Optional: define JOHNSON_HOLD_OK_EN to treat a repeated legal code as a benign hold instead of an error.
module johnson_code_checker #(
  parameter int N        = 4,
  parameter int CNT_W    = 3,
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [N-1:0]     in_code,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic             out_legal,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);
  localparam logic [N-1:0] CODE_ONE = N'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * N - 1);

  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED_ST} state_t;

  state_t           state, state_n;
  logic [RUN_W-1:0] run, run_n;
  logic             seq_err_n;
  logic             prev_valid, prev_legal;
  logic [CNT_W-1:0] prev_count;
  logic             legal, good, hold;
  logic [CNT_W-1:0] count, succ;

  // Legal codes have their ones (or, with msb set, their zeros) packed at the LSB end.
  function automatic logic is_legal(input logic [N-1:0] code);
    logic [N-1:0] c;
    c = code[N-1] ? ~code : code;
    return (c & (c + CODE_ONE)) == '0;
  endfunction

  function automatic logic [CNT_W-1:0] decode(input logic [N-1:0] code);
    int k;
    k = 0;
    for (int i = 0; i < N; i++) k += int'(code[i]);
    return code[N-1] ? CNT_W'(2 * N - k) : CNT_W'(k);
  endfunction

  always_comb begin
    legal = is_legal(in_code);
    count = legal ? decode(in_code) : '0;
    succ  = (prev_count == CNT_LAST) ? '0 : prev_count + CNT_W'(1);
    good  = legal && prev_valid && prev_legal && (count == succ);
    hold  = 1'b0;
`ifdef JOHNSON_HOLD_OK_EN
    hold  = legal && prev_valid && prev_legal && (count == prev_count);
`endif
  end

  always_comb begin
    state_n   = state;
    run_n     = run;
    seq_err_n = 1'b0;
    if (in_valid && !hold) begin
      case (state)
        UNLOCKED: begin
          if (good) begin
            run_n   = RUN_W'(1);
            state_n = (LOCK_LEN == 1) ? LOCKED_ST : LOCKING;
          end else begin
            run_n = '0;
          end
        end
        LOCKING: begin
          if (good) begin
            run_n = run + RUN_W'(1);
            if (int'(run) + 1 >= LOCK_LEN) state_n = LOCKED_ST;
          end else begin
            run_n   = '0;
            state_n = UNLOCKED;
          end
        end
        LOCKED_ST: begin
          if (!good) begin
            seq_err_n = 1'b1;
            run_n     = '0;
            state_n   = UNLOCKED;
          end
        end
        default: begin
          run_n   = '0;
          state_n = UNLOCKED;
        end
      endcase
    end
  end

  // Output/prev register stage: results appear one cycle after the sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= UNLOCKED;
      run        <= '0;
      out_valid  <= 1'b0;
      out_count  <= '0;
      out_legal  <= 1'b0;
      seq_err    <= 1'b0;
      err_count  <= '0;
      prev_valid <= 1'b0;
      prev_legal <= 1'b0;
      prev_count <= '0;
    end else begin
      state     <= state_n;
      run       <= run_n;
      out_valid <= in_valid;
      seq_err   <= seq_err_n;
      if (in_valid) begin
        out_count  <= count;
        out_legal  <= legal;
        prev_valid <= 1'b1;
        prev_legal <= legal;
        prev_count <= count;
      end
      if (seq_err_n && (err_count != '1)) err_count <= err_count + ERR_W'(1);
    end
  end

  assign locked = (state == LOCKED_ST);

endmodule

// File: tb/tb_johnson_code_checker.sv
// Randomized and directed bench for johnson_code_checker against a table-driven reference model.
module tb_johnson_code_checker;

  localparam int N = 4;
  localparam int CNT_W = 3;
  localparam int LOCK_LEN = 3;
  localparam int ERR_W = 2;
  localparam int MODULUS = 2 * N;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [N-1:0]     in_code;
  logic             out_valid;
  logic [CNT_W-1:0] out_count;
  logic             out_legal;
  logic             seq_err;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  johnson_code_checker #(.N(N), .CNT_W(CNT_W), .LOCK_LEN(LOCK_LEN), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_code(in_code),
    .out_valid(out_valid), .out_count(out_count), .out_legal(out_legal),
    .seq_err(seq_err), .locked(locked), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference tables: Johnson sequence built from its definition.
  int code2cnt[16];
  int cnt2code[MODULUS];

  // Reference model state
  bit m_ov, m_legal, m_seq, m_locked, m_pv, m_pl;
  int m_cnt, m_run, m_err, m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_clear();
    m_ov = 0; m_legal = 0; m_seq = 0; m_locked = 0; m_pv = 0; m_pl = 0;
    m_cnt = 0; m_run = 0; m_err = 0; m_pc = 0;
  endtask

  task automatic model_step(input bit v, input logic [N-1:0] c);
    bit lg, good, hold;
    int cnt;
    m_ov = v;
    m_seq = 0;
    if (v) begin
      lg = code2cnt[c] >= 0;
      cnt = lg ? code2cnt[c] : 0;
      good = lg && m_pv && m_pl && (cnt == (m_pc + 1) % MODULUS);
      hold = 0;
`ifdef JOHNSON_HOLD_OK_EN
      hold = lg && m_pv && m_pl && (cnt == m_pc);
`endif
      if (!hold) begin
        if (m_locked) begin
          if (!good) begin
            m_seq = 1;
            m_locked = 0;
            m_run = 0;
            if (m_err < ERR_MAX) m_err++;
          end
        end else if (good) begin
          m_run++;
          if (m_run >= LOCK_LEN) m_locked = 1;
        end else begin
          m_run = 0;
        end
      end
      m_pv = 1; m_pl = lg; m_pc = cnt;
      m_cnt = cnt; m_legal = lg;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    check({tag, ".out_count"}, 32'(out_count), 32'(m_cnt));
    check({tag, ".out_legal"}, 32'(out_legal), 32'(m_legal));
    check({tag, ".seq_err"}, 32'(seq_err), 32'(m_seq));
    check({tag, ".locked"}, 32'(locked), 32'(m_locked));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_err));
  endtask

  task automatic step(input string tag, input bit v, input logic [N-1:0] c);
    @(negedge clk);
    reset = 1'b0;
    in_valid = v;
    in_code = c;
    @(posedge clk);
    #1;
    model_step(v, c);
    compare_all(tag);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      in_code = 4'($urandom);
      @(posedge clk);
      #1;
      check("rst.out_valid", 32'(out_valid), 0);
      check("rst.out_count", 32'(out_count), 0);
      check("rst.out_legal", 32'(out_legal), 0);
      check("rst.seq_err", 32'(seq_err), 0);
      check("rst.locked", 32'(locked), 0);
      check("rst.err_count", 32'(err_count), 0);
    end
    model_clear();
  endtask

  initial begin
    logic [N-1:0] code;
    int last;
    bit v;
    for (int i = 0; i < 16; i++) code2cnt[i] = -1;
    for (int c = 0; c < MODULUS; c++) begin
      cnt2code[c] = (c <= N) ? (1 << c) - 1 : ((1 << N) - 1) ^ ((1 << (c - N)) - 1);
      code2cnt[cnt2code[c]] = c;
    end
    reset = 1'b1;
    in_valid = 1'b0;
    in_code = '0;
    model_clear();

    // T1: reset with random inputs
    do_reset(3);

    // T2: every 4-bit code
    for (int i = 0; i < 16; i++) step("decode", 1'b1, 4'(i));
    step("decode_0101", 1'b1, 4'b0101);
    check("decode_0101.legal_const", 32'(out_legal), 0);
    check("decode_0101.count_const", 32'(out_count), 0);
    step("decode_1100", 1'b1, 4'b1100);
    check("decode_1100.count_const", 32'(out_count), 6);

    // T3: lock and wrap
    do_reset(1);
    step("lock", 1'b1, 4'b0000);
    step("lock", 1'b1, 4'b0001);
    step("lock", 1'b1, 4'b0011);
    check("lock.not_yet", 32'(locked), 0);
    step("lock", 1'b1, 4'b0111);
    check("lock.locked_const", 32'(locked), 1);
    step("wrap", 1'b1, 4'b1111);
    step("wrap", 1'b1, 4'b1110);
    step("wrap", 1'b1, 4'b1100);
    step("wrap", 1'b1, 4'b1000);
    step("wrap", 1'b1, 4'b0000);
    check("wrap.locked_const", 32'(locked), 1);

    // T4: skip while locked, then relock
    step("err", 1'b1, 4'b0001);
    step("err", 1'b1, 4'b0011);
    step("err", 1'b1, 4'b1111);
    check("err.seq_const", 32'(seq_err), 1);
    check("err.cnt_const", 32'(err_count), 1);
    check("err.unlocked_const", 32'(locked), 0);
    step("relock", 1'b1, 4'b1110);
    check("relock.pulse_gone", 32'(seq_err), 0);
    step("relock", 1'b1, 4'b1100);
    step("relock", 1'b1, 4'b1000);
    check("relock.locked_const", 32'(locked), 1);

    // T5: illegal code errors and saturation
    do_reset(1);
    for (int r = 0; r < 5; r++) begin
      step("sat", 1'b1, 4'b0000);
      step("sat", 1'b1, 4'b0001);
      step("sat", 1'b1, 4'b0011);
      step("sat", 1'b1, 4'b0111);
      step("sat", 1'b1, 4'b0101);
      check("sat.err_const", 32'(err_count), (r < 3) ? r + 1 : 3);
      check("sat.seq_const", 32'(seq_err), 1);
    end

    // T6: gaps between codes, then a repeated code while locked
    do_reset(1);
    for (int c = 0; c < 11; c++) begin
      step("gap", 1'b1, 4'(cnt2code[c % MODULUS]));
      if (c >= 3) for (int g = 0; g < 4; g++) step("gap_idle", 1'b0, 4'($urandom));
    end
    check("gap.locked_const", 32'(locked), 1);
    check("gap.err_const", 32'(err_count), 0);
    step("repeat", 1'b1, 4'b0011);
`ifdef JOHNSON_HOLD_OK_EN
    check("repeat.seq_const", 32'(seq_err), 0);
    check("repeat.locked_const", 32'(locked), 1);
`else
    check("repeat.seq_const", 32'(seq_err), 1);
    check("repeat.locked_const", 32'(locked), 0);
`endif

    // Random stream biased toward successors
    do_reset(1);
    last = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: code = 4'(cnt2code[(last + 1) % MODULUS]);
        6:                code = 4'(cnt2code[last]);
        default:          code = 4'($urandom);
      endcase
      v = ($urandom_range(0, 3) != 0);
      if (v && code2cnt[code] >= 0) last = code2cnt[code];
      step("rand", v, code);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
